instr_mem_fetch: RTL and testbench

Parametrised, clocked successor to the combinational instruction ROM. It holds a program in a DEPTH-word array written through a load port while in LOAD mode. In RUN mode it serves word-aligned PC fetches with a one-cycle registered latency, plus stall and flush controls driven by the hazard-detection unit. It sits between the PC register and the IF/ID pipeline register.

---
 rtl/imem_pkg.sv | 31 +++
 rtl/instr_mem_fetch_if.sv | 34 +++
 rtl/imem_addr_chk.sv | 26 ++
 rtl/instr_mem_fetch.sv | 168 ++++++++++++++++
 tb/tb_instr_mem_fetch.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Purpose: shared types, defaults and byte-address helpers for the instruction memory.
// Contents: state_t (LOAD/RUN), NOP_WORD_DEFAULT, word_index / word_aligned / word_in_range.
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Helpers work on a fixed wide address so any ADDR_W up to this width is compared in full.
  localparam int unsigned CHK_ADDR_W = 64;

  // Byte address to word index.
  function automatic logic [CHK_ADDR_W-1:0] word_index(input logic [CHK_ADDR_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  // Word alignment check on the two byte-offset bits.
  function automatic logic word_aligned(input logic [1:0] byte_ofs);
    return byte_ofs == 2'b00;
  endfunction

  // Full-width range check: no upper bits are dropped, so large addresses never alias.
  function automatic logic word_in_range(input logic [CHK_ADDR_W-1:0] byte_addr,
                                         input int unsigned          depth);
    return word_index(byte_addr) < CHK_ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Purpose: load/fetch bus between the hazard/PC side (master) and the instruction memory (slave).
// Signals: ld_we/ld_addr/ld_data/ld_done (load port), fetch_req/pc/stall/flush (fetch control),
//          instr/instr_valid/misalign/oor/ld_err/running (memory responses).
interface instr_mem_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic              fetch_req;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              misalign;
  logic              oor;
  logic              ld_err;
  logic              running;

  modport master (
    output ld_we, ld_addr, ld_data, ld_done, fetch_req, pc, stall, flush,
    input  instr, instr_valid, misalign, oor, ld_err, running
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, ld_done, fetch_req, pc, stall, flush,
    output instr, instr_valid, misalign, oor, ld_err, running
  );

endinterface

// File: rtl/imem_addr_chk.sv
// Purpose: combinational byte-address decode shared by the load and fetch ports.
// Ports: i_addr (byte address), o_idx_c (word index, meaningful only when in range),
//        o_aligned_c (addr[1:0] == 0), o_in_range_c (word index < DEPTH).
module imem_addr_chk
  import imem_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [IDX_W-1:0]  o_idx_c,
  output logic              o_aligned_c,
  output logic              o_in_range_c
);

  logic [CHK_ADDR_W-1:0] w_addr_ext;
  logic [CHK_ADDR_W-1:0] w_index;

  assign w_addr_ext   = CHK_ADDR_W'(i_addr);
  assign w_index      = word_index(w_addr_ext);
  assign o_idx_c      = IDX_W'(w_index);
  assign o_aligned_c  = word_aligned(i_addr[1:0]);
  assign o_in_range_c = word_in_range(w_addr_ext, DEPTH);

endmodule

// File: rtl/instr_mem_fetch.sv
// Purpose: loadable instruction memory with one-cycle registered fetch, stall and flush.
// Ports: clk, rst (async, active-high), bus (instr_mem_fetch_if.slave):
//   load port ld_we/ld_addr/ld_data/ld_done, fetch port fetch_req/pc/stall/flush,
//   outputs instr/instr_valid/misalign/oor (fetch result), ld_err (sticky), running (RUN state).
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 64,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_fetch_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_misalign;
  logic              r_oor;
  logic              r_ld_err;

  logic [DATA_W-1:0] w_instr_nxt;
  logic              w_valid_nxt;
  logic              w_misalign_nxt;
  logic              w_oor_nxt;
  logic              w_ld_err_nxt;
  logic              w_ld_write;

  logic [IDX_W-1:0]  w_ld_idx;
  logic              w_ld_aligned;
  logic              w_ld_in_range;
  logic [IDX_W-1:0]  w_pc_idx;
  logic              w_pc_aligned;
  logic              w_pc_in_range;
  logic [DATA_W-1:0] w_rd_word;

  // Address decode for the load port.
  imem_addr_chk #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ld_chk (
    .i_addr       (bus.ld_addr),
    .o_idx_c      (w_ld_idx),
    .o_aligned_c  (w_ld_aligned),
    .o_in_range_c (w_ld_in_range)
  );

  // Address decode for the fetch port.
  imem_addr_chk #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_pc_chk (
    .i_addr       (bus.pc),
    .o_idx_c      (w_pc_idx),
    .o_aligned_c  (w_pc_aligned),
    .o_in_range_c (w_pc_in_range)
  );

  assign w_rd_word = r_mem[w_pc_idx];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: LOAD exits on ld_done; RUN is left only through reset.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == LOAD) && bus.ld_done) begin
      w_state_nxt = RUN;
    end
  end

  // Output / datapath control for the current state.
  always_comb begin
    w_instr_nxt    = NOP_WORD;
    w_valid_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    w_oor_nxt      = 1'b0;
    w_ld_err_nxt   = r_ld_err;
    w_ld_write     = 1'b0;

    unique case (r_state)
      LOAD: begin
        // Fetches are ignored while loading; outputs stay cleared.
        if (bus.ld_we) begin
          if (w_ld_aligned && w_ld_in_range) begin
            w_ld_write = 1'b1;
          end else begin
            w_ld_err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.ld_we) begin
          w_ld_err_nxt = 1'b1;
        end
        // Flush falls through to the cleared defaults and beats stall.
        if (!bus.flush) begin
          if (bus.stall) begin
            w_instr_nxt    = r_instr;
            w_valid_nxt    = r_valid;
            w_misalign_nxt = r_misalign;
            w_oor_nxt      = r_oor;
          end else if (bus.fetch_req) begin
            if (!w_pc_aligned) begin
              w_misalign_nxt = 1'b1;
            end else if (!w_pc_in_range) begin
              w_oor_nxt = 1'b1;
            end else begin
              w_instr_nxt = w_rd_word;
              w_valid_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Program array: reset to NOP, written only from the load port in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: NOP_WORD};
    end else if (w_ld_write) begin
      r_mem[w_ld_idx] <= bus.ld_data;
    end
  end

  // Registered fetch result and sticky load error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_WORD;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_oor      <= 1'b0;
      r_ld_err   <= 1'b0;
    end else begin
      r_instr    <= w_instr_nxt;
      r_valid    <= w_valid_nxt;
      r_misalign <= w_misalign_nxt;
      r_oor      <= w_oor_nxt;
      r_ld_err   <= w_ld_err_nxt;
    end
  end

  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.misalign    = r_misalign;
  assign bus.oor         = r_oor;
  assign bus.ld_err      = r_ld_err;
  assign bus.running     = (r_state == RUN);

endmodule

// File: tb/tb_instr_mem_fetch.sv
module tb_instr_mem_fetch;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_mem_fetch_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  instr_mem_fetch #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .NOP_WORD (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic        oor;
    logic        err;
    logic        run;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic        m_run, m_err, m_valid, m_mis, m_oor;
  logic [31:0] m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: evaluates the rules at each edge and queues the expected post-edge outputs.
  always @(posedge clk or posedge rst) begin
    int unsigned idx;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = NOP;
      m_run = 0; m_err = 0; m_valid = 0; m_mis = 0; m_oor = 0; m_instr = NOP;
      q.delete();
    end else begin
      if (!m_run) begin
        if (bus.ld_we) begin
          idx = bus.ld_addr / 4;
          if ((bus.ld_addr % 4 == 0) && (idx < DEPTH)) m_mem[IW'(idx)] = bus.ld_data;
          else m_err = 1;
        end
        m_instr = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
        if (bus.ld_done) m_run = 1;
      end else begin
        if (bus.ld_we) m_err = 1;
        idx = bus.pc / 4;
        if (bus.flush) begin
          m_instr = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
        end else if (bus.stall) begin
        end else if (!bus.fetch_req) begin
          m_instr = NOP; m_valid = 0; m_mis = 0; m_oor = 0;
        end else if (bus.pc % 4 != 0) begin
          m_instr = NOP; m_valid = 0; m_mis = 1; m_oor = 0;
        end else if (idx >= DEPTH) begin
          m_instr = NOP; m_valid = 0; m_mis = 0; m_oor = 1;
        end else begin
          m_instr = m_mem[IW'(idx)]; m_valid = 1; m_mis = 0; m_oor = 0;
        end
      end
      q.push_back('{m_instr, m_valid, m_mis, m_oor, m_err, m_run});
    end
  end

  // Monitor: compares DUT outputs against the queued expectation every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_instr", bus.instr, NOP);
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_flags", {bus.misalign, bus.oor, bus.ld_err, bus.running}, 0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("instr",    bus.instr, e.instr);
      chk("valid",    32'(bus.instr_valid), 32'(e.valid));
      chk("misalign", 32'(bus.misalign), 32'(e.mis));
      chk("oor",      32'(bus.oor), 32'(e.oor));
      chk("ld_err",   32'(bus.ld_err), 32'(e.err));
      chk("running",  32'(bus.running), 32'(e.run));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_we = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 0;
    bus.fetch_req = 0; bus.pc = '0; bus.stall = 0; bus.flush = 0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    idle();
    bus.ld_we = 1; bus.ld_addr = addr; bus.ld_data = data;
    step();
    idle();
  endtask

  task automatic fetch(input logic [31:0] addr);
    idle();
    bus.fetch_req = 1; bus.pc = addr;
    step();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    if (sel < 7)      return 32'($urandom_range(0, DEPTH - 1)) << 2;
    else if (sel < 8) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    else if (sel < 9) return (32'(DEPTH * 4) * 32'($urandom_range(1, 8))) + (32'($urandom_range(0, DEPTH - 1)) << 2);
    else              return $urandom;
  endfunction

  task automatic random_session(input int unsigned cycles);
    do_reset();
    repeat ($urandom_range(4, 20)) begin
      idle();
      bus.ld_we     = ($urandom_range(0, 9) != 0);
      bus.ld_addr   = rand_addr();
      bus.ld_data   = $urandom;
      bus.fetch_req = $urandom_range(0, 1);
      bus.pc        = rand_addr();
      step();
    end
    idle();
    bus.ld_done = 1;
    step();
    repeat (cycles) begin
      bus.fetch_req = ($urandom_range(0, 9) < 8);
      bus.pc        = rand_addr();
      bus.stall     = ($urandom_range(0, 99) < 15);
      bus.flush     = ($urandom_range(0, 99) < 8);
      bus.ld_we     = ($urandom_range(0, 99) < 3);
      bus.ld_addr   = rand_addr();
      bus.ld_data   = $urandom;
      bus.ld_done   = ($urandom_range(0, 99) < 5);
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Fetch while loading is ignored
    fetch(32'd0);
    chk("load_fetch_valid", 32'(bus.instr_valid), 0);
    chk("load_running", 32'(bus.running), 0);

    load(32'd0, 32'h2010_0030);
    load(32'd4, 32'h2011_0024);

    // ld_done with a same-edge fetch: the fetch is dropped
    idle();
    bus.ld_done = 1; bus.fetch_req = 1; bus.pc = 32'd0;
    step();
    chk("done_running", 32'(bus.running), 1);
    chk("done_fetch_valid", 32'(bus.instr_valid), 0);

    fetch(32'd0);
    chk("fetch0", bus.instr, 32'h2010_0030);
    chk("fetch0_valid", 32'(bus.instr_valid), 1);
    bus.pc = 32'd4;
    step();
    chk("fetch4", bus.instr, 32'h2011_0024);

    bus.stall = 1; bus.pc = 32'd8;
    repeat (3) begin
      step();
      chk("stall_hold", bus.instr, 32'h2011_0024);
      chk("stall_valid", 32'(bus.instr_valid), 1);
    end
    bus.flush = 1;
    step();
    chk("flush_instr", bus.instr, NOP);
    chk("flush_valid", 32'(bus.instr_valid), 0);

    fetch(32'd6);
    chk("misalign", 32'(bus.misalign), 1);
    chk("misalign_valid", 32'(bus.instr_valid), 0);
    fetch(32'd256);
    chk("oor", 32'(bus.oor), 1);
    chk("oor_noalias", bus.instr, NOP);

    load(32'd8, 32'hDEAD_BEEF);
    chk("run_ld_err", 32'(bus.ld_err), 1);
    fetch(32'd8);
    chk("word2_unchanged", bus.instr, NOP);
    chk("word2_valid", 32'(bus.instr_valid), 1);

    // Asynchronous reset between edges after a valid fetch
    fetch(32'd0);
    chk("pre_rst_instr", bus.instr, 32'h2010_0030);
    #2;
    rst = 1;
    #1;
    chk("async_rst_valid", 32'(bus.instr_valid), 0);
    chk("async_rst_running", 32'(bus.running), 0);
    idle();
    step();
    rst = 0;

    chk("ld_err_cleared", 32'(bus.ld_err), 0);
    load(32'd3, 32'h1234_5678);
    chk("load_misalign_err", 32'(bus.ld_err), 1);
    idle();
    bus.ld_done = 1;
    step();
    fetch(32'd0);
    chk("reloaded_nop", bus.instr, NOP);
    chk("reloaded_valid", 32'(bus.instr_valid), 1);

    repeat (4) random_session(200);

    idle();
    step();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
